// File: rtl/alu_pipe_if.sv
// Request/response bundle between the register-read stage, alu_pipe and writeback.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, carry_clr, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_n, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, carry_clr, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_n, flag_v
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, full flag set, an architectural
// carry register and an iterative shift-add multiplier.
module alu_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MUL_EN = 1
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave io_bus
);

  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_LTS  = 4'd11;
  localparam logic [3:0] OP_LTU  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_flag_n;
  logic             r_flag_v;
  logic             r_carry;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_arith;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_neg;
  logic [WIDTH-1:0] w_mag;

  assign w_in_ready = rst_n && (r_state == ST_IDLE) && (!r_out_valid || io_bus.out_ready);
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_is_mul   = (io_bus.op == OP_MUL) && (MUL_EN != 0);

  // Single-cycle datapath; b doubles as a signed shift amount.
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_arith = 1'b0;
    w_neg   = io_bus.b[MSB];
    w_mag   = w_neg ? (~io_bus.b + WIDTH'(1)) : io_bus.b;
    case (io_bus.op)
      OP_ADD, OP_ADDC: begin
        w_arith = 1'b1;
        w_sum   = {1'b0, io_bus.a} + {1'b0, io_bus.b}
                + ((io_bus.op == OP_ADDC) ? (WIDTH+1)'(r_carry) : (WIDTH+1)'(0));
        w_res   = w_sum[WIDTH-1:0];
        w_c     = w_sum[WIDTH];
        w_v     = (io_bus.a[MSB] == io_bus.b[MSB]) && (w_sum[MSB] != io_bus.a[MSB]);
      end
      OP_SUB, OP_SUBC: begin
        w_arith = 1'b1;
        w_sum   = {1'b0, io_bus.a} - {1'b0, io_bus.b}
                - ((io_bus.op == OP_SUBC) ? (WIDTH+1)'(r_carry) : (WIDTH+1)'(0));
        w_res   = w_sum[WIDTH-1:0];
        w_c     = w_sum[WIDTH];
        w_v     = (io_bus.a[MSB] != io_bus.b[MSB]) && (w_sum[MSB] != io_bus.a[MSB]);
      end
      OP_SLL:  w_res = w_neg ? (io_bus.a >> w_mag) : (io_bus.a << w_mag);
      OP_SRL:  w_res = w_neg ? (io_bus.a << w_mag) : (io_bus.a >> w_mag);
      OP_SRA:  w_res = w_neg ? (io_bus.a << w_mag) : $unsigned($signed(io_bus.a) >>> w_mag);
      OP_AND:  w_res = io_bus.a & io_bus.b;
      OP_OR:   w_res = io_bus.a | io_bus.b;
      OP_XOR:  w_res = io_bus.a ^ io_bus.b;
      OP_NOT:  w_res = ~io_bus.a;
      OP_LTS:  w_res = WIDTH'($signed(io_bus.a) < $signed(io_bus.b));
      OP_LTU:  w_res = WIDTH'(io_bus.a < io_bus.b);
      default: w_res = '0;
    endcase
  end

  // Control FSM, output register and carry register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flag_z    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_v    <= 1'b0;
      r_carry     <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      if (r_out_valid && io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (io_bus.carry_clr) begin
        r_carry <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state  <= ST_MUL;
            r_mcand  <= io_bus.a;
            r_mplier <= io_bus.b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_flag_z    <= (w_res == '0);
            r_flag_n    <= w_res[MSB];
            r_flag_c    <= w_c;
            r_flag_v    <= w_v;
            // An arithmetic commit overrides a same-cycle clear.
            if (w_arith) begin
              r_carry <= w_c;
            end
          end
        end
        ST_MUL: begin
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b1;
            r_result    <= r_acc;
            r_flag_z    <= (r_acc == '0);
            r_flag_n    <= r_acc[MSB];
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
          end else begin
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.result    = r_result;
  assign io_bus.flag_z    = r_flag_z;
  assign io_bus.flag_c    = r_flag_c;
  assign io_bus.flag_n    = r_flag_n;
  assign io_bus.flag_v    = r_flag_v;

endmodule
